// File: rtl/rtc_key_scheduler.sv
// Single-clock RTC key-change scheduler: 500 Hz tick enable, epoch timer and key-rotation req/ack handshake.
// Optional build macro MANUAL_ADVANCE_EN enables force_change as a manual key advance.
module rtc_key_scheduler #(
  parameter int unsigned CLK_HZ           = 1000000,
  parameter int unsigned TICK_HZ          = 500,
  parameter int unsigned KEYCHANGE_PERIOD = 5,
  parameter int unsigned NUM_KEYS         = 4,
  parameter int unsigned ACK_TIMEOUT      = 16
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        key_ack,
  input  logic                        clear_err,
  input  logic                        force_change,
  output logic                        tick_500hz,
  output logic                        key_req,
  output logic [$clog2(NUM_KEYS)-1:0] req_idx,
  output logic [$clog2(NUM_KEYS)-1:0] key_idx,
  output logic                        busy,
  output logic                        timeout_err,
  output logic                        overrun_err
);

  localparam int unsigned PRE_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned EP_LEN  = TICK_HZ * KEYCHANGE_PERIOD;
  localparam int unsigned EP_W    = (EP_LEN > 1) ? $clog2(EP_LEN) : 1;
  localparam int unsigned IDX_W   = $clog2(NUM_KEYS);
  localparam int unsigned TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX     = PRE_W'(PRE_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_RESTART = (PRE_DIV > 1) ? PRE_W'(1) : PRE_W'(0);
  localparam logic [EP_W-1:0]  EP_MAX      = EP_W'(EP_LEN - 1);
  localparam logic [TO_W-1:0]  TO_MAX      = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_KEYS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_REQ = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [EP_W-1:0]  ep_q, ep_d;
  logic             tick_q, tick_d;
  logic             epoch_q, epoch_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [IDX_W-1:0] key_idx_q, key_idx_d;
  logic [IDX_W-1:0] req_idx_q, req_idx_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;

  logic             force_req;
  logic             restart;
  logic             start;

  // Explicit wrap so non-power-of-two slot counts rotate correctly.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? IDX_W'(0) : idx + IDX_ONE;
  endfunction

`ifdef MANUAL_ADVANCE_EN
  assign force_req = force_change;
`else
  logic unused_force_change;
  assign unused_force_change = force_change;
  assign force_req           = 1'b0;
`endif

  // A manual advance restarts the whole period; the advancing cycle counts as its first.
  assign restart = force_req && (state_q == ST_RUN);
  assign start   = epoch_q || force_req;

  always_comb begin
    pre_d   = pre_q;
    ep_d    = ep_q;
    tick_d  = 1'b0;
    epoch_d = 1'b0;
    if (restart) begin
      pre_d = enable ? PRE_RESTART : PRE_W'(0);
      ep_d  = EP_W'(0);
    end else if (enable) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = PRE_W'(0);
        tick_d = 1'b1;
        if (ep_q == EP_MAX) begin
          ep_d    = EP_W'(0);
          epoch_d = 1'b1;
        end else begin
          ep_d = ep_q + EP_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Handshake FSM; error sets are evaluated after clear so a coincident set wins.
  always_comb begin
    state_d   = state_q;
    to_d      = to_q;
    key_idx_d = key_idx_q;
    req_idx_d = req_idx_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (clear_err) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end
    case (state_q)
      ST_RUN: begin
        if (start) begin
          state_d = ST_REQ;
          to_d    = TO_W'(0);
        end
      end
      ST_REQ: begin
        if (start) begin
          overrun_d = 1'b1;
        end
        if (key_ack) begin
          state_d   = ST_RUN;
          key_idx_d = req_idx_q;
          req_idx_d = next_idx(req_idx_q);
        end else if (to_q == TO_MAX) begin
          state_d   = ST_RUN;
          timeout_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      pre_q     <= PRE_W'(0);
      ep_q      <= EP_W'(0);
      tick_q    <= 1'b0;
      epoch_q   <= 1'b0;
      to_q      <= TO_W'(0);
      key_idx_q <= IDX_W'(0);
      req_idx_q <= IDX_ONE;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      ep_q      <= ep_d;
      tick_q    <= tick_d;
      epoch_q   <= epoch_d;
      to_q      <= to_d;
      key_idx_q <= key_idx_d;
      req_idx_q <= req_idx_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign tick_500hz  = tick_q;
  assign key_req     = (state_q == ST_REQ);
  assign busy        = (state_q == ST_REQ);
  assign req_idx     = req_idx_q;
  assign key_idx     = key_idx_q;
  assign timeout_err = timeout_q;
  assign overrun_err = overrun_q;

endmodule

// File: doc/rtc_key_scheduler.md
Name: rtc_key_scheduler

Overview:
Single-clock scheduler for the RTC key-change subsystem. Replaces derived divider clocks with one-cycle enables on sys_clk. Produces a 500 Hz display/scan tick and runs the periodic key-rotation sequence. Every KEYCHANGE_PERIOD seconds it issues a req/ack handshake to the key-register bank, selecting the next key slot, with timeout and overrun detection.

Parameters:
CLK_HZ, 1000000, sys_clk frequency in Hz
TICK_HZ, 500, tick_500hz rate; CLK_HZ must be an integer multiple
KEYCHANGE_PERIOD, 5, seconds between key changes; do not rename
NUM_KEYS, 4, key slots rotated through (>=2)
ACK_TIMEOUT, 16, max sys_clk cycles key_req stays high without key_ack

Ports:
sys_clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
enable  in  1  1 = prescaler/epoch counters run; 0 = hold
key_ack  in  1  key bank accepted req_idx
clear_err  in  1  one-cycle pulse, clears sticky error flags
force_change  in  1  manual key advance (used only with MANUAL_ADVANCE_EN)
tick_500hz  out  1  one-cycle pulse at TICK_HZ
key_req  out  1  key-change request
req_idx  out  $clog2(NUM_KEYS)  slot requested; stable while key_req=1
key_idx  out  $clog2(NUM_KEYS)  currently active slot
busy  out  1  1 while FSM is in REQ
timeout_err  out  1  sticky: request timed out
overrun_err  out  1  sticky: epoch arrived while request pending

Behaviour:
- Reset (rst_n=0 at posedge): all counters 0, FSM=RUN, all outputs 0, key_idx=0, req_idx=1 mod NUM_KEYS.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 while enable=1; tick_500hz=1 in the cycle after the wrap (registered). Holds value when enable=0, and no ticks occur.
- Epoch counter: advances on each tick; range 0..TICK_HZ*KEYCHANGE_PERIOD-1. Wrap raises internal epoch pulse, coincident with that tick_500hz.
- req_idx = (key_idx+1) mod NUM_KEYS at all times. Explicit wrap at NUM_KEYS-1 -> 0; NUM_KEYS need not be a power of 2.
- FSM states: RUN, REQ.
  - RUN: epoch pulse in cycle N -> key_req=1, busy=1 from cycle N+1; state=REQ; timeout counter cleared.
  - REQ: key_ack=1 sampled at a posedge with key_req=1 -> next cycle key_req=0, key_idx<=req_idx, state=RUN. An ack in the first cycle of key_req is valid. key_ack in RUN is ignored.
  - REQ timeout: after ACK_TIMEOUT cycles with no ack -> key_req=0, timeout_err=1, key_idx unchanged, state=RUN.
  - Epoch while in REQ: overrun_err=1. No second request is queued and key_idx does not double-advance.
- Ack and timeout expiry in the same cycle: the ack wins and no error is raised.
- clear_err clears both flags. If clear_err coincides with a new error event, the error set wins.
- enable=0 during REQ: the handshake still completes or times out. Only the counters freeze.
- Reset mid-REQ: key_req drops the next cycle and key_idx returns to 0. The key bank must tolerate an abandoned request.

Optional Feature:
MANUAL_ADVANCE_EN
- Defined: a force_change pulse in RUN starts a request exactly like an epoch and also clears the epoch counter to 0, restarting the full period. force_change in REQ sets overrun_err. force_change coincident with an epoch counts as one request.
- Undefined: the force_change port exists but is ignored. Key rotation is purely periodic.

Test Plan:
Use CLK_HZ=20, TICK_HZ=5, KEYCHANGE_PERIOD=2, NUM_KEYS=3, ACK_TIMEOUT=4 (tick every 4 cycles, epoch every 40 cycles).
- Reset release, enable=1, key_ack tied 1 -> tick_500hz at cycles 4,8,12,...; key_req high for 1 cycle at cycle 41; key_idx 0->1 at cycle 42, then 2, then wraps to 0 on the third epoch.
- enable=0 for 10 cycles after cycle 20 -> ticks shift by 10; first key_req at cycle 51.
- key_ack held 0 -> key_req high exactly 4 cycles; timeout_err=1; key_idx stays 0. clear_err pulse -> timeout_err=0 next cycle.
- key_ack held 0 and ACK_TIMEOUT=100 -> second epoch at cycle 80 sets overrun_err, key_req stays high. Ack at 85 -> key_idx=1, not 2.
- rst_n=0 for one cycle while key_req=1 -> key_req=0, key_idx=0, flags 0, and the next tick arrives 4 cycles after release.
- MANUAL_ADVANCE_EN defined, force_change at cycle 25 -> key_req at 26. Ack -> key_idx=1; next epoch request at cycle 66.
